// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display scanner.
// Holds the segment bit positions of the active-low seg_n bus and the
// hex-digit-to-segment table.
package seg7_pkg;

  // Segment bit positions within seg_n: [6:0] = g..a, [7] = decimal point.
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;
  localparam int unsigned SEG_W  = 8;

  // Active-low g..a pattern for a hex nibble (A-F shown as A,b,C,d,E,F).
  function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational hex decoder for one display digit.
// Ports:
//   nibble - hex value to show
//   dp     - decimal point, 1 = lit
//   blank  - force segments g..a off (decimal point unaffected)
//   seg_n  - active-low segment bus, [6:0] = g..a, [7] = dp
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             dp,
  input  logic             blank,
  output logic [SEG_W-1:0] seg_n
);

  always_comb begin
    seg_n = '1;
    if (!blank) begin
      seg_n[SEG_G:SEG_A] = hex_to_seg_n(nibble);
    end
    seg_n[SEG_DP] = ~dp;
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed multi-digit 7-segment display scanner with tear-free updates,
// leading-zero blanking and PWM brightness control.
// Ports:
//   clk, rst    - clock; synchronous active-high reset
//   number      - hex nibbles, nibble i drives digit i (digit 0 = LSD)
//   dot         - decimal point per digit, 1 = lit
//   blank_lz    - leading-zero blanking enable
//   upd         - one-cycle request to load number/dot/blank_lz at next frame
//   brightness  - PWM duty level, all ones = full on
//   sel_n       - active-low digit enables (registered)
//   seg_n       - active-low segments, [6:0] = g..a, [7] = dp (registered)
//   frame_tick  - high during the frame-boundary cycle (registered)
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 12500,
  parameter int unsigned DIM_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     dot,
  input  logic                  blank_lz,
  input  logic                  upd,
  input  logic [DIM_BITS-1:0]   brightness,
  output logic [DIGITS-1:0]     sel_n,
  output logic [SEG_W-1:0]      seg_n,
  output logic                  frame_tick
);

  localparam int unsigned NUM_W = 4 * DIGITS;
  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [PRE_W-1:0]    pre_q,   pre_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [DIM_BITS-1:0] pwm_q,   pwm_d;
  logic                pend_q,  pend_d;
  logic [NUM_W-1:0]    num_q,   num_d;
  logic [DIGITS-1:0]   dot_q,   dot_d;
  logic                blz_q,   blz_d;
  logic [DIGITS-1:0]   sel_n_q, sel_n_d;
  logic [SEG_W-1:0]    seg_n_q, seg_n_d;
  logic                frame_q, frame_d;

  logic                slot_tick;
  logic                boundary;
  logic                capture;
  logic [DIGITS-1:0]   lz;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic [SEG_W-1:0]    dec_seg_n;

  // lz[i] = all shadow nibbles from i up to the top digit are zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz       = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      all_zero = all_zero && (num_q[4*i +: 4] == 4'h0);
      lz[i]    = all_zero;
    end
  end

  // Current digit fields, taken from the shadows only; digit 0 is never blanked.
  always_comb begin
    cur_nib   = num_q[4*int'(idx_q) +: 4];
    cur_dp    = dot_q[idx_q];
    cur_blank = blz_q && (idx_q != '0) && lz[idx_q];
  end

  seg7_dec u_dec (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .blank  (cur_blank),
    .seg_n  (dec_seg_n)
  );

  // Next-state logic for the scan timebase, shadows and output registers.
  always_comb begin
    slot_tick = (pre_q == PRE_LAST);
    boundary  = slot_tick && (idx_q == IDX_LAST);

    pre_d = slot_tick ? '0 : pre_q + PRE_W'(1);

    idx_d = idx_q;
    if (slot_tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    pwm_d = slot_tick ? '0 : pwm_q + DIM_BITS'(1);

    // An upd on the boundary cycle itself is captured immediately.
    capture = boundary && (pend_q || upd);
    pend_d  = boundary ? 1'b0 : (pend_q || upd);

    num_d = capture ? number   : num_q;
    dot_d = capture ? dot      : dot_q;
    blz_d = capture ? blank_lz : blz_q;

    // Registered so that it is high during the boundary cycle itself.
    frame_d = (pre_d == PRE_LAST) && (idx_d == IDX_LAST);

    sel_n_d = '1;
    if (pwm_q <= brightness) begin
      sel_n_d[idx_q] = 1'b0;
    end
    seg_n_d = dec_seg_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      idx_q   <= '0;
      pwm_q   <= '0;
      pend_q  <= 1'b0;
      num_q   <= '0;
      dot_q   <= '0;
      blz_q   <= 1'b0;
      sel_n_q <= '1;
      seg_n_q <= '1;
      frame_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      pwm_q   <= pwm_d;
      pend_q  <= pend_d;
      num_q   <= num_d;
      dot_q   <= dot_d;
      blz_q   <= blz_d;
      sel_n_q <= sel_n_d;
      seg_n_q <= seg_n_d;
      frame_q <= frame_d;
    end
  end

  assign sel_n      = sel_n_q;
  assign seg_n      = seg_n_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: stimulus queues expected per-cycle outputs,
// a monitor pops and compares them at the matching cycle.
module tb_seg7_scan;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned PRESCALE = 8;
  localparam int unsigned DIM_BITS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] number = 16'h0000;
  logic [3:0]  dot = 4'b0000;
  logic        blank_lz = 1'b0;
  logic        upd = 1'b0;
  logic [1:0]  brightness = 2'd3;
  logic [3:0]  sel_n;
  logic [7:0]  seg_n;
  logic        frame_tick;

  seg7_scan #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE),
    .DIM_BITS (DIM_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .number     (number),
    .dot        (dot),
    .blank_lz   (blank_lz),
    .upd        (upd),
    .brightness (brightness),
    .sel_n      (sel_n),
    .seg_n      (seg_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Cycle number since the last reset edge (cycle 0 has prescaler 0).
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int         c;
    logic       in_rst;
    logic [3:0] sel;
    logic [7:0] seg;
    logic       ft;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // frame_tick is expected on the last cycle of every 32-cycle frame.
  task automatic push(input int c, input logic r, input logic [3:0] s,
                      input logic [7:0] g, input string nm);
    exp_t e;
    e.c      = c;
    e.in_rst = r;
    e.sel    = s;
    e.seg    = g;
    e.ft     = !r && ((c % 32) == 31);
    e.name   = nm;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    int g = 0;
    while (cyc != t && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != t) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_cyc: at cycle %0d, required cycle %0d", cyc, t);
    end
  endtask

  // Monitor: sample 2 time units after each rising edge.
  always begin
    exp_t e;
    @(posedge clk);
    #2;
    while (q.size() > 0 && q[0].in_rst == rst && q[0].c <= cyc) begin
      e = q.pop_front();
      n_checks++;
      if (e.c != cyc) begin
        n_fail++;
        $display("FAIL %s: missed, sampled at cycle %0d, required cycle %0d",
                 e.name, cyc, e.c);
      end else if (sel_n !== e.sel || seg_n !== e.seg || frame_tick !== e.ft) begin
        n_fail++;
        $display("FAIL %s @%0d: sel_n=%b seg_n=%h frame_tick=%b, expected sel_n=%b seg_n=%h frame_tick=%b",
                 e.name, cyc, sel_n, seg_n, frame_tick, e.sel, e.seg, e.ft);
      end
    end
  end

  initial begin
    // Reset and first frame (shadows zero, all digits '0').
    repeat (3) push(0, 1'b1, 4'b1111, 8'hFF, "reset");
    push(1,   1'b0, 4'b1110, 8'hC0, "init_d0");
    push(5,   1'b0, 4'b1110, 8'hC0, "init_d0_mid");
    push(8,   1'b0, 4'b1110, 8'hC0, "slot0_end");
    push(9,   1'b0, 4'b1101, 8'hC0, "slot1_start");
    push(12,  1'b0, 4'b1101, 8'hC0, "slot1_mid");
    push(30,  1'b0, 4'b0111, 8'hC0, "pre_frame_tick");
    push(31,  1'b0, 4'b0111, 8'hC0, "frame_tick_1");
    push(32,  1'b0, 4'b0111, 8'hC0, "post_frame_tick");
    // 16'h1234 loaded at first boundary.
    push(33,  1'b0, 4'b1110, 8'h99, "upd1234_d0");
    push(40,  1'b0, 4'b1110, 8'h99, "upd1234_d0_end");
    push(41,  1'b0, 4'b1101, 8'hB0, "upd1234_d1");
    push(49,  1'b0, 4'b1011, 8'hA4, "upd1234_d2");
    push(57,  1'b0, 4'b0111, 8'hF9, "upd1234_d3");
    push(63,  1'b0, 4'b0111, 8'hF9, "frame_tick_2");
    push(64,  1'b0, 4'b0111, 8'hF9, "wrap_d3");
    push(65,  1'b0, 4'b1110, 8'h99, "wrap_d0");
    // Mid-frame upd of 16'hABCD: old value until boundary.
    push(84,  1'b0, 4'b1011, 8'hA4, "tear_old_d2");
    push(89,  1'b0, 4'b0111, 8'hF9, "tear_old_d3");
    push(95,  1'b0, 4'b0111, 8'hF9, "tear_old_bnd");
    push(96,  1'b0, 4'b0111, 8'hF9, "tear_old_last");
    push(97,  1'b0, 4'b1110, 8'hA1, "tear_new_d0");
    push(105, 1'b0, 4'b1101, 8'hC6, "tear_new_d1");
    push(113, 1'b0, 4'b1011, 8'h83, "tear_new_d2");
    push(121, 1'b0, 4'b0111, 8'h88, "tear_new_d3");
    // upd on the boundary cycle: 16'h0050, blank_lz, dp on digit 3.
    push(127, 1'b0, 4'b0111, 8'h88, "bnd_upd_cycle");
    push(128, 1'b0, 4'b0111, 8'h88, "bnd_upd_old");
    push(129, 1'b0, 4'b1110, 8'hC0, "bnd_d0");
    push(137, 1'b0, 4'b1101, 8'h92, "bnd_d1");
    push(145, 1'b0, 4'b1011, 8'hFF, "blank_d2");
    push(153, 1'b0, 4'b0111, 8'h7F, "blank_d3_dp");
    push(169, 1'b0, 4'b1101, 8'h92, "no_upd_hold");
    push(185, 1'b0, 4'b0111, 8'h7F, "pending_old_d3");
    // number 0 with blanking: only digit 0 lit.
    push(193, 1'b0, 4'b1110, 8'hC0, "zero_d0");
    push(201, 1'b0, 4'b1101, 8'hFF, "zero_d1");
    push(209, 1'b0, 4'b1011, 8'hFF, "zero_d2");
    push(217, 1'b0, 4'b0111, 8'hFF, "zero_d3");
    // brightness 0: lit on PWM 0 only (2 of 8 cycles).
    push(225, 1'b0, 4'b1110, 8'hC0, "dim_on_a");
    push(226, 1'b0, 4'b1111, 8'hC0, "dim_off_a");
    push(228, 1'b0, 4'b1111, 8'hC0, "dim_off_b");
    push(229, 1'b0, 4'b1110, 8'hC0, "dim_on_b");
    push(230, 1'b0, 4'b1111, 8'hC0, "dim_off_c");
    push(232, 1'b0, 4'b1111, 8'hC0, "dim_off_d");
    push(233, 1'b0, 4'b1101, 8'hFF, "dim_on_d1");
    push(234, 1'b0, 4'b1111, 8'hFF, "dim_off_d1");
    // brightness 3 restored: full on.
    push(241, 1'b0, 4'b1011, 8'hFF, "bright_a");
    push(242, 1'b0, 4'b1011, 8'hFF, "bright_b");
    push(244, 1'b0, 4'b1011, 8'hFF, "bright_c");

    repeat (3) @(negedge clk);
    rst = 1'b0;

    wait_cyc(2);
    number = 16'h1234;
    upd    = 1'b1;
    @(negedge clk);
    upd    = 1'b0;

    wait_cyc(80);
    number = 16'hABCD;
    upd    = 1'b1;
    @(negedge clk);
    upd    = 1'b0;

    wait_cyc(127);
    number   = 16'h0050;
    blank_lz = 1'b1;
    dot      = 4'b1000;
    upd      = 1'b1;
    @(negedge clk);
    upd      = 1'b0;

    wait_cyc(130);
    number = 16'h0000;

    wait_cyc(170);
    number   = 16'h0000;
    blank_lz = 1'b1;
    dot      = 4'b0000;
    upd      = 1'b1;
    @(negedge clk);
    upd      = 1'b0;

    wait_cyc(224);
    brightness = 2'd0;
    wait_cyc(240);
    brightness = 2'd3;

    // Reset mid-scan at index 2, prescaler 5.
    wait_cyc(277);
    repeat (3) push(0, 1'b1, 4'b1111, 8'hFF, "midscan_reset");
    push(1,  1'b0, 4'b1110, 8'hC0, "restart_d0");
    push(8,  1'b0, 4'b1110, 8'hC0, "restart_slot0_full");
    push(9,  1'b0, 4'b1101, 8'hC0, "restart_d1");
    push(31, 1'b0, 4'b0111, 8'hC0, "restart_frame_tick");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    wait_cyc(40);

    while (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: never sampled, required cycle %0d", q[0].name, q[0].c);
      void'(q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter PRESCALE, default 12500, clk cycles per digit slot (>= 2**DIM_BITS).
REQ-003 SHALL have parameter DIM_BITS, default 3, brightness resolution in bits (1..6).
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port number  input  4*DIGITS  hex nibbles; nibble i [4i+3:4i] drives digit i, digit 0 least significant.
REQ-007 SHALL have port dot  input  DIGITS  decimal point per digit, 1 = lit.
REQ-008 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-009 SHALL have port upd  input  1  one-cycle request to load number/dot/blank_lz into the shadow registers.
REQ-010 SHALL have port brightness  input  DIM_BITS  duty level; all ones = full on.
REQ-011 SHALL have port sel_n  output  DIGITS  digit enables, active-low, at most one low.
REQ-012 SHALL have port seg_n  output  8  segments, active-low, [6:0] = g..a, [7] = dp.
REQ-013 SHALL have port frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-014 Prescaler SHALL count 0..PRESCALE-1 and wrap; slot tick = cycle on which prescaler equals PRESCALE-1.
REQ-015 Digit index SHALL advance by 1 on each slot tick, wrapping from DIGITS-1 to 0.
REQ-016 Frame boundary SHALL be the slot tick on which the index wraps from DIGITS-1 to 0; frame_tick SHALL be high for exactly that cycle.
REQ-017 upd SHALL set a pending flag; at the next frame boundary, if pending, the shadows SHALL capture the inputs present on that cycle and pending SHALL clear.
REQ-018 upd coincident with a frame boundary SHALL capture on that same cycle and leave pending clear.
REQ-019 Display SHALL use only shadow values; input changes without upd SHALL never alter the outputs.
REQ-020 Hex decode SHALL be full 0-F (A-F as A,b,C,d,E,F); e.g. 0 -> seg_n 8'hC0, 4 -> 8'h99 when dp is off.
REQ-021 With shadow blank_lz=1, every digit above the highest non-zero nibble SHALL show segments [6:0] all off; digit 0 SHALL always be shown; dp SHALL be unaffected by blanking.
REQ-022 A DIM_BITS-bit PWM counter SHALL increment every clk, wrap freely, and reset to 0 on each slot tick.
REQ-023 The selected digit's sel_n bit SHALL be low only while PWM counter <= brightness; otherwise sel_n SHALL be all ones.
REQ-024 sel_n and seg_n SHALL be registered; they SHALL reflect the new index one cycle after the slot tick (latency 1).
REQ-025 brightness SHALL be sampled directly (no shadow) and take effect on the next cycle.

Reset
REQ-026 While rst=1: sel_n all ones, seg_n 8'hFF, frame_tick 0, prescaler 0, index 0, PWM counter 0, pending 0, shadows 0.
REQ-027 Assertion of rst mid-slot or mid-frame SHALL abort scanning; the first cycle after release SHALL begin slot 0 from prescaler 0.

Structure
REQ-028 The hex-to-7-segment table and segment bit positions SHALL live in shared package seg7_pkg.
REQ-029 Decode SHALL be a sub-module seg7_dec (nibble, dp, blank -> seg_n), combinational, one instance.

Verification (DIGITS=4, PRESCALE=8, DIM_BITS=2, brightness=3 unless stated)
REQ-030 Reset: hold rst 3 cycles -> sel_n 4'b1111, seg_n 8'hFF; release, upd with number 16'h1234 -> after next frame boundary digit 0 shows seg_n 8'h99.
REQ-031 Scan/wrap: free run -> sel_n 1110,1101,1011,0111,1110 each low 8 cycles; frame_tick every 32 cycles.
REQ-032 Tearing: upd with 16'hABCD at mid-frame -> old value on all digits until boundary, new value from next slot 0; upd at boundary -> captured same cycle.
REQ-033 Blanking: number 16'h0050, blank_lz=1 -> digits 3,2 blank (seg_n 8'hFF), digit 1 '5', digit 0 '0' (8'hC0); number 0 -> only digit 0 lit.
REQ-034 Brightness: brightness=0 -> selected sel_n bit low 2 of 8 cycles per slot; brightness=3 -> 8 of 8.
REQ-035 Reset mid-scan at index 2, prescaler 5 -> outputs at reset values; after release, slot 0 restarts with full 8-cycle duration.
